// File: rtl/fu_issue_sched_pkg.sv
// fu_issue_sched shared definitions
// FU class encoding, sizes and issue-slot index map
package fu_issue_sched_pkg;

    localparam int RS_SIZE = 16;
    localparam int NUM_ALU = 2;
    localparam int NUM_FU  = NUM_ALU + 3;
    localparam int IDX_W   = $clog2(RS_SIZE);

    localparam int FU_ALU0_IDX = 0;
    localparam int FU_MULT_IDX = NUM_ALU;
    localparam int FU_MEM_IDX  = NUM_ALU + 1;
    localparam int FU_BR_IDX   = NUM_ALU + 2;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MULT = 2'd1,
        FU_MEM  = 2'd2,
        FU_BR   = 2'd3
    } FU_CLASS_T;

    typedef logic [IDX_W-1:0] rs_idx_t;

endpackage

// File: rtl/fu_issue_sched_if.sv
// fu_issue_sched RS-side / FU-side bundle
// master = reservation station + FU consumers, slave = scheduler
interface fu_issue_sched_if;
    import fu_issue_sched_pkg::*;

    logic                                enable;
    logic                                squash;
    logic      [RS_SIZE-1:0]             entry_ready;
    FU_CLASS_T [RS_SIZE-1:0]             entry_class;
    logic      [RS_SIZE-1:0]             entry_is_store;
    logic      [1:0]                     LSQ_busy;
    logic      [RS_SIZE-1:0]             issue_grant;
    logic      [NUM_FU-1:0]              slot_valid;
    logic      [NUM_FU-1:0][IDX_W-1:0]   slot_rs_idx;
    logic      [NUM_FU-1:0]              fu_busy_out;
    logic                                mult_busy;

    modport master (
        output enable, squash, entry_ready, entry_class,
        output entry_is_store, LSQ_busy,
        input  issue_grant, slot_valid, slot_rs_idx,
        input  fu_busy_out, mult_busy
    );

    modport slave (
        input  enable, squash, entry_ready, entry_class,
        input  entry_is_store, LSQ_busy,
        output issue_grant, slot_valid, slot_rs_idx,
        output fu_busy_out, mult_busy
    );

endinterface

// File: rtl/fu_issue_sched_rr_pick.sv
// Round-robin picker: first set request at or after i_ptr, wrapping
// Ports: i_req, i_ptr in; o_gnt one-hot, o_vld, o_idx out
module rr_pick
    import fu_issue_sched_pkg::*;
(
    input  logic [RS_SIZE-1:0] i_req,
    input  rs_idx_t            i_ptr,
    output logic [RS_SIZE-1:0] o_gnt,
    output logic               o_vld,
    output rs_idx_t            o_idx
);

    rs_idx_t w_pos;

    always_comb begin
        o_gnt = '0;
        o_vld = 1'b0;
        o_idx = '0;
        w_pos = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            // index arithmetic is IDX_W wide, so it wraps mod RS_SIZE
            w_pos = i_ptr + rs_idx_t'(i);
            if (!o_vld && i_req[w_pos]) begin
                o_vld        = 1'b1;
                o_idx        = w_pos;
                o_gnt[w_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fu_issue_sched.sv
// Issue scheduler: per-class round-robin pick from RS into FU slots
// Ports: i_clock, i_reset (async, active-low), io_sched (slave bundle)
module fu_issue_sched
    import fu_issue_sched_pkg::*;
#(
    parameter int MULT_LAT = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,
    fu_issue_sched_if.slave   io_sched
);

    localparam int CNT_W = $clog2(MULT_LAT) + 1;

    logic [RS_SIZE-1:0] w_alu_req, w_mult_req, w_mem_req, w_br_req;
    logic [NUM_ALU-1:0][RS_SIZE-1:0] w_alu_gnt;
    logic [NUM_ALU-1:0] w_alu_vld;
    rs_idx_t [NUM_ALU-1:0] w_alu_idx;
    logic [RS_SIZE-1:0] w_mult_gnt, w_mem_gnt, w_br_gnt;
    logic w_mult_raw, w_mem_raw, w_br_raw;
    logic w_mult_vld, w_mem_vld, w_br_vld;
    rs_idx_t w_mult_idx, w_mem_idx, w_br_idx, w_alu_last;
    logic w_go;
    logic [NUM_FU-1:0] w_g_vld;
    rs_idx_t [NUM_FU-1:0] w_g_idx;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [NUM_FU-1:0] r_slot_valid, r_fu_busy;
    rs_idx_t [NUM_FU-1:0] r_slot_idx;
    rs_idx_t r_ptr_alu, r_ptr_mult, r_ptr_mem, r_ptr_br;
    logic [CNT_W-1:0] r_mult_cnt;

    // reset term keeps issue_grant low while reset is held
    assign w_go = io_sched.enable & ~io_sched.squash & i_reset;

    always_comb begin
        w_alu_req  = '0;
        w_mult_req = '0;
        w_mem_req  = '0;
        w_br_req   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (io_sched.entry_ready[i]) begin
                unique case (io_sched.entry_class[i])
                    FU_ALU:  w_alu_req[i]  = 1'b1;
                    FU_MULT: w_mult_req[i] = 1'b1;
                    FU_MEM:  w_mem_req[i]  = io_sched.entry_is_store[i]
                                           ? ~io_sched.LSQ_busy[1]
                                           : ~io_sched.LSQ_busy[0];
                    FU_BR:   w_br_req[i]   = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // each ALU picker sees the requests left over by the ones before it
    for (genvar g = 0; g < NUM_ALU; g++) begin : g_alu
        logic [RS_SIZE-1:0] w_req;
        logic [RS_SIZE-1:0] w_gnt;
        logic               w_vld;
        rs_idx_t            w_idx;
        if (g == 0) begin : g_first
            assign w_req = w_alu_req;
        end else begin : g_next
            assign w_req = g_alu[g-1].w_req & ~g_alu[g-1].w_gnt;
        end
        rr_pick u_pick (
            .i_req (w_req),
            .i_ptr (r_ptr_alu),
            .o_gnt (w_gnt),
            .o_vld (w_vld),
            .o_idx (w_idx)
        );
        assign w_alu_gnt[g] = w_go ? w_gnt : '0;
        assign w_alu_vld[g] = w_go & w_vld;
        assign w_alu_idx[g] = w_idx;
    end

    rr_pick u_mult (
        .i_req (w_mult_req),
        .i_ptr (r_ptr_mult),
        .o_gnt (w_mult_gnt),
        .o_vld (w_mult_raw),
        .o_idx (w_mult_idx)
    );

    rr_pick u_mem (
        .i_req (w_mem_req),
        .i_ptr (r_ptr_mem),
        .o_gnt (w_mem_gnt),
        .o_vld (w_mem_raw),
        .o_idx (w_mem_idx)
    );

    rr_pick u_br (
        .i_req (w_br_req),
        .i_ptr (r_ptr_br),
        .o_gnt (w_br_gnt),
        .o_vld (w_br_raw),
        .o_idx (w_br_idx)
    );

    assign w_mult_vld = w_go & w_mult_raw & (r_mult_cnt == '0);
    assign w_mem_vld  = w_go & w_mem_raw;
    assign w_br_vld   = w_go & w_br_raw;

    always_comb begin
        w_g_vld    = '0;
        w_g_idx    = '0;
        w_alu_last = w_alu_idx[0];
        io_sched.issue_grant = '0;
        for (int a = 0; a < NUM_ALU; a++) begin
            w_g_vld[FU_ALU0_IDX+a] = w_alu_vld[a];
            w_g_idx[FU_ALU0_IDX+a] = w_alu_idx[a];
            io_sched.issue_grant  |= w_alu_gnt[a];
            if (w_alu_vld[a]) w_alu_last = w_alu_idx[a];
        end
        w_g_vld[FU_MULT_IDX] = w_mult_vld;
        w_g_idx[FU_MULT_IDX] = w_mult_idx;
        w_g_vld[FU_MEM_IDX]  = w_mem_vld;
        w_g_idx[FU_MEM_IDX]  = w_mem_idx;
        w_g_vld[FU_BR_IDX]   = w_br_vld;
        w_g_idx[FU_BR_IDX]   = w_br_idx;
        if (w_mult_vld) io_sched.issue_grant |= w_mult_gnt;
        if (w_mem_vld)  io_sched.issue_grant |= w_mem_gnt;
        if (w_br_vld)   io_sched.issue_grant |= w_br_gnt;
    end

    // counter keeps draining while issue is frozen; squash kills it
    always_comb begin
        w_cnt_nxt = r_mult_cnt;
        if (io_sched.squash)       w_cnt_nxt = '0;
        else if (w_mult_vld)       w_cnt_nxt = CNT_W'(MULT_LAT - 1);
        else if (r_mult_cnt != '0) w_cnt_nxt = r_mult_cnt - 1'b1;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_slot_valid <= '0;
            r_slot_idx   <= '0;
            r_fu_busy    <= '0;
            r_mult_cnt   <= '0;
            r_ptr_alu    <= '0;
            r_ptr_mult   <= '0;
            r_ptr_mem    <= '0;
            r_ptr_br     <= '0;
        end else begin
            r_slot_valid <= w_g_vld;
            r_mult_cnt   <= w_cnt_nxt;
            r_fu_busy    <= w_g_vld;
            r_fu_busy[FU_MULT_IDX] <= w_g_vld[FU_MULT_IDX] | (w_cnt_nxt != '0);
            for (int k = 0; k < NUM_FU; k++) begin
                if (w_g_vld[k]) r_slot_idx[k] <= w_g_idx[k];
            end
            if (w_alu_vld[0]) r_ptr_alu  <= w_alu_last + 1'b1;
            if (w_mult_vld)   r_ptr_mult <= w_mult_idx + 1'b1;
            if (w_mem_vld)    r_ptr_mem  <= w_mem_idx + 1'b1;
            if (w_br_vld)     r_ptr_br   <= w_br_idx + 1'b1;
        end
    end

    assign io_sched.slot_valid  = r_slot_valid;
    assign io_sched.slot_rs_idx = r_slot_idx;
    assign io_sched.fu_busy_out = r_fu_busy;
    assign io_sched.mult_busy   = (r_mult_cnt != '0);

endmodule

// File: doc/fu_issue_sched.md
Name: fu_issue_sched

Overview:
Issue scheduler between the reservation station (RS) and the functional units. Each cycle it picks ready RS entries per FU class, using per-class round-robin priority. It returns a combinational grant mask so the RS frees those entries at the same edge. It drives registered per-FU issue slots and tracks FU occupancy: a non-pipelined multiplier, and memory blocking from LSQ_busy.

Parameters:
RS_SIZE, 16, number of RS entries (power of 2)
NUM_ALU, 2, ALU issue slots per cycle
MULT_LAT, 4, cycles the multiplier is occupied per op (>=1)
NUM_FU, NUM_ALU+3, total slots: ALU0..ALU(n-1), MULT, MEM, BR

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  issue enable; 0 = freeze issue
squash  in  1  branch-mispredict flush
entry_ready  in  RS_SIZE  entry valid with all operands ready
entry_class  in  RS_SIZE x 2  FU_CLASS_T per entry
entry_is_store  in  RS_SIZE  MEM entry is a store (else load)
LSQ_busy  in  2  [0] load queue full, [1] store queue full
issue_grant  out  RS_SIZE  combinational mask of entries issued this cycle
slot_valid  out  NUM_FU  registered: slot holds an issued op
slot_rs_idx  out  NUM_FU x log2(RS_SIZE)  registered RS index per slot
fu_busy_out  out  NUM_FU  registered occupancy (slot_valid, with MULT held high while the counter is nonzero)
mult_busy  out  1  multiplier occupied (counter != 0)

Behaviour:
- Reset (reset=0, async): slot_valid=0, slot_rs_idx=0, fu_busy_out=0, mult counter=0, all RR pointers=0. issue_grant=0 while in reset.
- Grant logic (combinational, computed when enable=1 and squash=0):
  - ALU: scan entries from ptr_alu upward, with wrap-around. Grant the first NUM_ALU ready ALU entries, in scan order, to ALU0, ALU1, …
  - MULT: grant the first ready MULT entry from ptr_mult, only if the counter is 0.
  - MEM: a load is eligible only if LSQ_busy[0]=0; a store is eligible only if LSQ_busy[1]=0. Grant the first eligible entry from ptr_mem.
  - BR: grant the first ready BR entry from ptr_br.
  - issue_grant is the OR of all granted entry bits. Each entry is granted at most once.
- Posedge update:
  - slot_valid[k] <= slot k granted this cycle; slot_rs_idx[k] <= the granted index, or is held when the slot is not granted.
  - Issue-to-slot latency is 1 cycle.
- RR pointers: each class pointer <= (last granted index in that class + 1) mod RS_SIZE. With no grant, the pointer holds. Wrap from RS_SIZE-1 to 0 is required.
- Multiplier counter:
  - On a MULT grant, load MULT_LAT-1.
  - Otherwise decrement while nonzero. Decrementing continues regardless of enable.
  - With MULT_LAT=1, back-to-back mults issue every cycle.
- enable=0: issue_grant=0; slot_valid <= 0; pointers hold; mult counter keeps decrementing.
- squash=1 (overrides enable): issue_grant=0; slot_valid <= 0; mult counter <= 0; pointers hold.
- Entries with entry_ready=0 are never granted, whatever their class.

Decomposition:
- In the shared sys_defs.vh package:
  - FU_CLASS_T typedef: FU_ALU=2'd0, FU_MULT=2'd1, FU_MEM=2'd2, FU_BR=2'd3.
  - Slot index constants: FU_ALU0_IDX.., FU_MULT_IDX, FU_MEM_IDX, FU_BR_IDX.
  - RS_SIZE and NUM_FU defines.
- One sub-module, rr_pick: takes a request vector and a start pointer, returns a one-hot grant and a valid flag. It is instantiated once per class; the ALU class uses NUM_ALU chained instances that mask out earlier grants.

Test Plan:
1. Reset asserted mid-operation, with slot_valid=5'b11111 and the mult counter at 2. All outputs go to 0 immediately (asynchronously). After release, the first grant starts from pointer 0.
2. Entries 1, 3, 6 are ALU-ready, ptr_alu=0. issue_grant=16'h000A; next cycle ALU0 idx 1 and ALU1 idx 3 are valid. Hold entry 6 ready: it is granted next cycle, and ptr_alu becomes 7.
3. Wrap-around: ptr_alu=14, ALU-ready entries {15, 2}. Entry 15 goes to ALU0 and entry 2 to ALU1; ptr_alu becomes 3.
4. MULT_LAT=4: MULT entries 0 and 5 are ready continuously. Entry 0 is granted at cycle t; mult_busy stays high for 3 cycles; entry 5 is granted at t+4, not before.
5. LSQ_busy=2'b01, with load entry 2 and store entry 9 both ready. Only 9 is granted. Then set LSQ_busy=2'b11: no MEM grant and slot_valid[FU_MEM_IDX]=0.
6. squash during mult busy clears the counter and slots; a ready MULT is granted the next cycle. enable=0 with everything ready gives issue_grant=0; raising enable reissues from the unchanged pointers.
